// File: rtl/dispatch_pkg.sv
// Shared constants and types for the round-robin / directed beat dispatcher.
package dispatch_pkg;

  localparam int unsigned CH_N  = 4;
  localparam int unsigned CNT_W = 16;

  // Dispatcher FSM: StIdle holds nothing, StHold owns one beat in the output register.
  typedef enum logic {
    StIdle = 1'b0,
    StHold = 1'b1
  } state_e;

  localparam logic MODE_RR  = 1'b0;
  localparam logic MODE_DIR = 1'b1;

  // Channel index to one-hot valid vector.
  function automatic logic [CH_N-1:0] ch_onehot(input logic [1:0] idx);
    ch_onehot      = '0;
    ch_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: first set mask bit scanning ptr+1, ptr+2, ptr+3, ptr.
module rr_pick4 (
  input  logic [3:0] mask,
  input  logic [1:0] ptr,
  output logic [1:0] sel,
  output logic       any
);

  logic [1:0] idx;
  logic       found;

  // Rotating priority scan; sel falls back to ptr when nothing is enabled.
  always_comb begin
    sel   = ptr;
    idx   = '0;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      idx = ptr + 2'(k);
      if (!found && mask[idx]) begin
        sel   = idx;
        found = 1'b1;
      end
    end
  end

  assign any = |mask;

endmodule

// File: rtl/demux_rr_dispatcher.sv
// One-beat output-registered demux: steers each source beat to one of four channels,
// either round-robin over the enabled channels or directed by in_dest.
// Optional per-channel handshake counters are built when DISPATCH_STATS_EN is defined.
module demux_rr_dispatcher
  import dispatch_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic [1:0]        in_dest,
  output logic              in_ready,
  input  logic              mode,
  input  logic [3:0]        ch_en,
  output logic [3:0]        out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic [3:0]        out_ready,
`ifdef DISPATCH_STATS_EN
  input  logic              stat_clr,
  output logic [63:0]       stat_cnt,
`endif
  output logic              drop
);

  state_e            state_q, state_d;
  logic [1:0]        sel_q;
  logic [1:0]        ptr_q;
  logic [DATA_W-1:0] data_q;
  logic              drop_q;

  logic [1:0] rr_sel;
  logic       rr_any;
  logic       held_acc;
  logic       rr_blocked;
  logic [1:0] cap_ch;
  logic       xfer;
  logic       dir_drop;
  logic       load;

  rr_pick4 u_rr_pick4 (
    .mask (ch_en),
    .ptr  (ptr_q),
    .sel  (rr_sel),
    .any  (rr_any)
  );

  // Handshake decode: held-beat acceptance, source transfer, capture channel and drop.
  always_comb begin
    held_acc   = (state_q == StHold) && out_ready[sel_q];
    rr_blocked = (mode == MODE_RR) && !rr_any;
    cap_ch     = (mode == MODE_DIR) ? in_dest : rr_sel;
    // Reset forces ready low so no beat is taken while the block is being cleared.
    in_ready   = !rst && ((state_q == StIdle) || held_acc) && !rr_blocked;
    xfer       = in_valid && in_ready;
    dir_drop   = xfer && (mode == MODE_DIR) && !ch_en[in_dest];
    load       = xfer && !dir_drop;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a new load always wins; otherwise an accepted beat empties the register.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (load) state_d = StHold;
      StHold: begin
        if (load) begin
          state_d = StHold;
        end else if (held_acc) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs: valid only while a beat is held; data bus keeps the last beat after delivery.
  always_comb begin
    out_valid = (state_q == StHold) ? ch_onehot(sel_q) : 4'b0000;
    out_data  = data_q;
    drop      = drop_q;
  end

  // Datapath registers: captured beat, its channel, round-robin pointer, drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      sel_q  <= '0;
      ptr_q  <= 2'd3;
      drop_q <= 1'b0;
    end else begin
      drop_q <= dir_drop;
      if (load) begin
        data_q <= in_data;
        sel_q  <= cap_ch;
      end
      // Directed traffic leaves the round-robin position untouched.
      if (xfer && (mode == MODE_RR)) begin
        ptr_q <= rr_sel;
      end
    end
  end

`ifdef DISPATCH_STATS_EN
  logic [CNT_W-1:0] cnt_q [CH_N];

  // Per-channel output handshake counters; clear has priority over counting.
  always_ff @(posedge clk) begin
    if (rst || stat_clr) begin
      for (int i = 0; i < CH_N; i++) begin
        cnt_q[i] <= '0;
      end
    end else if (held_acc) begin
      cnt_q[sel_q] <= cnt_q[sel_q] + CNT_W'(1);
    end
  end

  // Pack counters with channel 0 in the low bits.
  always_comb begin
    stat_cnt = '0;
    for (int i = 0; i < CH_N; i++) begin
      stat_cnt[i*CNT_W +: CNT_W] = cnt_q[i];
    end
  end
`endif

endmodule

// File: doc/demux_rr_dispatcher.md
DEMUX_RR_DISPATCHER -- requirements
Module: demux_rr_dispatcher

Interface
REQ-001 Parameter: DATA_W, default 8, width of the data beat.
REQ-002 Port: clk  input  1  single clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: in_valid  input  1  source beat present.
REQ-005 Port: in_data  input  DATA_W  source beat payload.
REQ-006 Port: in_dest  input  2  destination channel, used in directed mode only.
REQ-007 Port: in_ready  output  1  dispatcher accepts beat this cycle.
REQ-008 Port: mode  input  1  0 = round-robin, 1 = directed.
REQ-009 Port: ch_en  input  4  per-channel enable mask.
REQ-010 Port: out_valid  output  4  one-hot per-channel valid.
REQ-011 Port: out_data  output  DATA_W  shared payload bus for all channels.
REQ-012 Port: out_ready  input  4  per-channel sink ready.
REQ-013 Port: drop  output  1  one-cycle pulse, a directed beat was discarded.

Function
REQ-014 The block SHALL use two states: IDLE (no beat held) and HOLD (one beat held in the output register).
REQ-015 A source beat SHALL transfer when in_valid && in_ready.
REQ-016 in_ready SHALL be 1 in IDLE, or in HOLD in the same cycle the held beat is accepted; otherwise 0.
REQ-017 In round-robin mode, in_ready SHALL be 0 when ch_en == 4'b0000.
REQ-018 Round-robin selection SHALL pick the first enabled channel scanning ptr+1, ptr+2, ptr+3, ptr (mod 4); ptr SHALL update to the chosen channel on transfer.
REQ-019 In directed mode, the channel SHALL be in_dest; ptr SHALL NOT change.
REQ-020 A directed beat with ch_en[in_dest] == 0 SHALL be accepted, discarded, and SHALL raise drop for exactly the next cycle; the state SHALL remain or become IDLE.
REQ-021 A transferred, non-dropped beat SHALL appear on out_data/out_valid in the next cycle: latency 1 cycle.
REQ-022 In HOLD, out_valid SHALL equal one-hot(sel), and out_data SHALL hold stable until out_ready[sel] == 1.
REQ-023 out_ready bits for non-selected channels SHALL be ignored.
REQ-024 Held-beat acceptance plus a new transfer in the same cycle SHALL keep HOLD and load the new beat, giving full throughput of 1 beat/cycle.
REQ-025 Held-beat acceptance with no new transfer SHALL return the block to IDLE, with out_valid = 0 and out_data retaining its last value.
REQ-026 Changes to mode, ch_en or in_dest SHALL affect only the next capture; a held beat is never retracted or rerouted, even if its channel is disabled.

Reset
REQ-027 While rst is high at a clock edge, the block SHALL reset to: state IDLE, out_valid 4'b0000, out_data 0, drop 0, ptr 2'd3 (first round-robin pick is channel 0), and all statistic counters 0.
REQ-028 Reset mid-HOLD SHALL discard the held beat without delivering it; in_ready SHALL be 0 during the reset cycle.

Configuration
REQ-029 Macro DISPATCH_STATS_EN SHALL control the statistics feature.
REQ-030 When DISPATCH_STATS_EN is defined, the block SHALL add input stat_clr (1 bit) and output stat_cnt (64 bits), containing four 16-bit counters with channel 0 in [15:0].
REQ-031 Each counter SHALL increment on that channel's output handshake and SHALL wrap from 16'hFFFF to 0.
REQ-032 stat_clr SHALL zero all counters and SHALL win over a simultaneous increment.
REQ-033 When DISPATCH_STATS_EN is undefined, the ports and logic SHALL be absent, and all other behaviour SHALL be identical.

Structure
REQ-034 Shared package dispatch_pkg SHALL hold CH_N = 4, the state encoding (IDLE/HOLD), the mode encoding (MODE_RR = 0, MODE_DIR = 1), and CNT_W = 16.
REQ-035 Round-robin priority selection SHALL be a sub-module rr_pick4 with inputs mask[3:0] and ptr[1:0], and outputs sel[1:0] and any.

Verification
REQ-036 Scenario: reset, then mode=0, ch_en=4'b1111, out_ready=4'b1111, 4 beats A1..A4 back-to-back -> out_valid 0001, 0010, 0100, 1000 on consecutive cycles, each 1 cycle after its input.
REQ-037 Scenario: mode=0, ch_en=4'b1010, 3 beats -> delivered to channels 1, 3, 1.
REQ-038 Scenario: mode=1, in_dest=2, ch_en[2]=1, out_ready=0 for 5 cycles then 1 -> out_valid=0100 with data stable 5 cycles; in_ready=0 until release.
REQ-039 Scenario: mode=1, in_dest=3, ch_en=4'b0111 -> beat accepted, drop=1 for 1 cycle, out_valid stays 0000.
REQ-040 Scenario: rst asserted while HOLD with out_ready=0 -> next cycle out_valid=0000, out_data=0; the next round-robin beat goes to channel 0.
REQ-041 Scenario (DISPATCH_STATS_EN defined): 65537 beats to channel 0 -> stat_cnt[15:0]=1; stat_clr asserted during a handshake -> 0.
